// File: rtl/genesis3_pkg.sv
// Shared definitions for the genesis3 simulation library arithmetic cells:
// operation encoding and the two's-complement overflow detector.
package genesis3_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow occurs when the carry into the sign bit differs from the carry out of it.
    function automatic logic signed_overflow(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

endpackage

// File: rtl/carry_chain_accum_if.sv
// Operand/result bundle of the carry-chain accumulator; the DUT takes the slave view.
interface carry_chain_accum_if #(
    parameter int WIDTH = 8
);
    logic             E;
    logic [WIDTH-1:0] D;
    logic             SUB;
    logic             CLR;
    logic             LD;
    logic [WIDTH-1:0] L;
    logic [WIDTH-1:0] Q;
    logic             QV;
    logic             CO;
    logic             OV;

    modport slave  (input  E, D, SUB, CLR, LD, L, output Q, QV, CO, OV);
    modport master (output E, D, SUB, CLR, LD, L, input  Q, QV, CO, OV);
endinterface

// File: rtl/carry_chain_accum_carry_chain.sv
// Per-bit adder_carry primitive and a WIDTH-bit ripple chain built from it,
// exposing the carries into and out of the MSB for overflow detection.
module adder_carry (
    input  logic p,
    input  logic g,
    input  logic cin,
    output logic cout,
    output logic sumout
);
    assign sumout = p ^ cin;
    assign cout   = g | (p & cin);
endmodule

module carry_chain #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout_msb,
    output logic             cin_msb
);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign p[gi] = a[gi] ^ b[gi];
            assign g[gi] = a[gi] & b[gi];
            adder_carry u_cell (
                .p      (p[gi]),
                .g      (g[gi]),
                .cin    (carry[gi]),
                .cout   (carry[gi+1]),
                .sumout (sum[gi])
            );
        end
    endgenerate

    assign cout_msb = carry[WIDTH];
    assign cin_msb  = carry[WIDTH-1];
endmodule

// File: rtl/carry_chain_accum.sv
// Two-stage registered add/subtract accumulator: operand register, then a ripple
// carry chain feeding the Q register with carry-out and sticky signed overflow.
module carry_chain_accum
    import genesis3_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}}
) (
    input  logic C,
    input  logic R,
    carry_chain_accum_if.slave bus
);
    logic [WIDTH-1:0] d1_q, d1_d;
    logic             c1_q, c1_d;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qv_q, qv_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] sum;
    logic             cout_msb;
    logic             cin_msb;

    // Subtraction is Q + ~D + 1: the inverted operand is stored and the +1 enters as carry-in.
    carry_chain #(.WIDTH(WIDTH)) u_chain (
        .a        (q_q),
        .b        (d1_q),
        .cin      (c1_q),
        .sum      (sum),
        .cout_msb (cout_msb),
        .cin_msb  (cin_msb)
    );

    always_comb begin
        d1_d = d1_q;
        c1_d = c1_q;
        v1_d = 1'b0;
        q_d  = q_q;
        qv_d = 1'b0;
        co_d = co_q;
        ov_d = ov_q;
        if (bus.CLR) begin
            q_d  = INIT_VALUE;
            co_d = 1'b0;
            ov_d = 1'b0;
        end else begin
            if (bus.E) begin
                d1_d = (bus.SUB == OP_ADD) ? bus.D : ~bus.D;
                c1_d = (bus.SUB == OP_SUB);
                v1_d = 1'b1;
            end
            // A load wins over the in-flight operand, which is simply discarded.
            if (bus.LD) begin
                q_d = bus.L;
            end else if (v1_q) begin
                q_d  = sum;
                co_d = cout_msb;
                qv_d = 1'b1;
                ov_d = ov_q | signed_overflow(cin_msb, cout_msb);
            end
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            d1_q <= '0;
            c1_q <= 1'b0;
            v1_q <= 1'b0;
            q_q  <= INIT_VALUE;
            qv_q <= 1'b0;
            co_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            d1_q <= d1_d;
            c1_q <= c1_d;
            v1_q <= v1_d;
            q_q  <= q_d;
            qv_q <= qv_d;
            co_q <= co_d;
            ov_q <= ov_d;
        end
    end

    assign bus.Q  = q_q;
    assign bus.QV = qv_q;
    assign bus.CO = co_q;
    assign bus.OV = ov_q;
endmodule

// File: tb/tb_carry_chain_accum.sv
// Scoreboarded bench for carry_chain_accum: a behavioural model pushes expected
// results at each edge, a negedge monitor pops them when QV pulses.
module tb_carry_chain_accum;
    localparam int         WIDTH = 8;
    localparam logic [7:0] INIT  = 8'h05;

    logic clk = 1'b0;
    logic rst = 1'b1;

    carry_chain_accum_if #(.WIDTH(WIDTH)) bus ();

    carry_chain_accum #(.WIDTH(WIDTH), .INIT_VALUE(INIT)) dut (
        .C   (clk),
        .R   (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic       co;
        logic       ov;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [7:0] m_q, m_d;
    logic       m_co, m_ov, m_v1, m_sub;

    task automatic model_reset();
        m_q  = INIT;
        m_d  = 8'h00;
        m_co = 1'b0;
        m_ov = 1'b0;
        m_v1 = 1'b0;
        m_sub = 1'b0;
        sb_q.delete();
    endtask

    // Behavioural reference: unsigned compare for borrow, sign rules for overflow.
    task automatic model_edge(input logic e, input logic [7:0] d, input logic sub,
                              input logic clr, input logic ld, input logic [7:0] l);
        logic [7:0] r;
        logic [8:0] wide;
        exp_t       x;
        if (rst) begin
            model_reset();
        end else if (clr) begin
            m_q  = INIT;
            m_co = 1'b0;
            m_ov = 1'b0;
            m_v1 = 1'b0;
        end else begin
            if (ld) begin
                m_q = l;
            end else if (m_v1) begin
                if (m_sub) begin
                    r    = m_q - m_d;
                    m_co = (m_q >= m_d);
                    m_ov = m_ov | ((m_q[7] != m_d[7]) && (r[7] != m_q[7]));
                end else begin
                    wide = {1'b0, m_q} + {1'b0, m_d};
                    r    = wide[7:0];
                    m_co = wide[8];
                    m_ov = m_ov | ((m_q[7] == m_d[7]) && (r[7] != m_q[7]));
                end
                m_q  = r;
                x.q  = m_q;
                x.co = m_co;
                x.ov = m_ov;
                sb_q.push_back(x);
            end
            m_v1 = e;
            if (e) begin
                m_d   = d;
                m_sub = sub;
            end
        end
    endtask

    task automatic step(input logic e, input logic [7:0] d, input logic sub,
                        input logic clr, input logic ld, input logic [7:0] l);
        bus.E   = e;
        bus.D   = d;
        bus.SUB = sub;
        bus.CLR = clr;
        bus.LD  = ld;
        bus.L   = l;
        @(posedge clk);
        model_edge(e, d, sub, clr, ld, l);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        logic exp_qv;
        exp_qv = (sb_q.size() != 0);
        vectors++;
        if (bus.QV !== exp_qv) begin
            miscompares++;
            $display("FAIL sb_qv: QV=%b required %b at %0t", bus.QV, exp_qv, $time);
        end
        if (exp_qv) begin
            x = sb_q.pop_front();
            vectors++;
            if ({bus.Q, bus.CO, bus.OV} !== x) begin
                miscompares++;
                $display("FAIL sb_result: Q=%h CO=%b OV=%b required Q=%h CO=%b OV=%b",
                         bus.Q, bus.CO, bus.OV, x.q, x.co, x.ov);
            end else begin
                $display("txn Q=%h CO=%b OV=%b", bus.Q, bus.CO, bus.OV);
            end
        end
    end

    task automatic test_reset();
        repeat (3) step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.QV, bus.CO, bus.OV} !== {INIT, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_hold: Q=%h QV=%b CO=%b OV=%b required Q=%h 0 0 0",
                     bus.Q, bus.QV, bus.CO, bus.OV, INIT);
        end
        rst = 1'b0;
        step(0, 8'h00, 0, 0, 1, 8'h40);
        step(1, 8'h50, 0, 0, 0, 8'h00);
        step(1, 8'h11, 0, 0, 0, 8'h00);
        step(1, 8'h22, 0, 0, 0, 8'h00);
        // Reset lands between edges with E still asserted and a result just published.
        bus.E = 1'b1;
        rst   = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({bus.Q, bus.QV, bus.CO, bus.OV} !== {INIT, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_async: Q=%h QV=%b CO=%b OV=%b required Q=%h 0 0 0",
                     bus.Q, bus.QV, bus.CO, bus.OV, INIT);
        end
        step(1, 8'h33, 0, 0, 0, 8'h00);
        step(1, 8'h33, 0, 0, 0, 8'h00);
        rst = 1'b0;
        step(1, 8'h01, 0, 0, 0, 8'h00);
        vectors++;
        if (bus.Q !== INIT) begin
            miscompares++;
            $display("FAIL reset_release_q1: Q=%h required %h", bus.Q, INIT);
        end
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if (bus.Q !== 8'h06) begin
            miscompares++;
            $display("FAIL reset_first_add: Q=%h required 06", bus.Q);
        end
    endtask

    task automatic test_add_wrap();
        step(0, 8'h00, 0, 0, 1, 8'hFE);
        step(1, 8'h03, 0, 0, 0, 8'h00);
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.CO, bus.OV, bus.QV} !== {8'h01, 3'b101}) begin
            miscompares++;
            $display("FAIL add_wrap: Q=%h CO=%b OV=%b QV=%b required 01 1 0 1",
                     bus.Q, bus.CO, bus.OV, bus.QV);
        end
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if (bus.QV !== 1'b0) begin
            miscompares++;
            $display("FAIL add_wrap_pulse: QV=%b required 0", bus.QV);
        end
    endtask

    task automatic test_overflow();
        step(0, 8'h00, 0, 0, 1, 8'h7F);
        step(1, 8'h01, 0, 0, 0, 8'h00);
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.OV} !== {8'h80, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_set: Q=%h OV=%b required 80 1", bus.Q, bus.OV);
        end
        step(1, 8'h01, 0, 0, 0, 8'h00);
        step(0, 8'h00, 0, 0, 0, 8'h00);
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.OV} !== {8'h81, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_sticky: Q=%h OV=%b required 81 1", bus.Q, bus.OV);
        end
        step(0, 8'h00, 0, 1, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.OV, bus.CO} !== {INIT, 2'b00}) begin
            miscompares++;
            $display("FAIL ovf_clr: Q=%h OV=%b CO=%b required %h 0 0", bus.Q, bus.OV, bus.CO, INIT);
        end
    endtask

    task automatic test_subtract();
        step(0, 8'h00, 0, 0, 1, 8'h02);
        step(1, 8'h03, 1, 0, 0, 8'h00);
        step(1, 8'h01, 1, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.CO} !== {8'hFF, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_borrow: Q=%h CO=%b required FF 0", bus.Q, bus.CO);
        end
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.CO} !== {8'hFE, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_noborrow: Q=%h CO=%b required FE 1", bus.Q, bus.CO);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tbl [4];
        tbl = '{8'h01, 8'h03, 8'h06, 8'h0A};
        step(0, 8'h00, 0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1, 8'(i + 1), 0, 0, 0, 8'h00);
            else       step(0, 8'h00, 0, 0, 0, 8'h00);
            if (i > 0) begin
                vectors++;
                if ({bus.Q, bus.QV} !== {tbl[i-1], 1'b1}) begin
                    miscompares++;
                    $display("FAIL b2b_%0d: Q=%h QV=%b required %h 1", i, bus.Q, bus.QV, tbl[i-1]);
                end
            end
        end
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if (bus.QV !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: QV=%b required 0", bus.QV);
        end
    endtask

    task automatic test_priority();
        step(0, 8'h00, 0, 0, 1, 8'h20);
        step(1, 8'h01, 0, 0, 0, 8'h00);
        step(1, 8'h09, 0, 1, 1, 8'h33);
        vectors++;
        if ({bus.Q, bus.QV} !== {INIT, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_clr: Q=%h QV=%b required %h 0", bus.Q, bus.QV, INIT);
        end
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.QV} !== {INIT, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_clr_drop: Q=%h QV=%b required %h 0", bus.Q, bus.QV, INIT);
        end
        step(1, 8'h07, 0, 0, 0, 8'h00);
        step(0, 8'h00, 0, 0, 1, 8'h10);
        vectors++;
        if ({bus.Q, bus.QV} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_ld_pending: Q=%h QV=%b required 10 0", bus.Q, bus.QV);
        end
        step(1, 8'h03, 0, 0, 1, 8'h20);
        step(0, 8'h00, 0, 0, 0, 8'h00);
        vectors++;
        if ({bus.Q, bus.QV} !== {8'h23, 1'b1}) begin
            miscompares++;
            $display("FAIL prio_ld_with_e: Q=%h QV=%b required 23 1", bus.Q, bus.QV);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.E   = 1'b0;
        bus.D   = 8'h00;
        bus.SUB = 1'b0;
        bus.CLR = 1'b0;
        bus.LD  = 1'b0;
        bus.L   = 8'h00;
        model_reset();
        test_reset();
        test_add_wrap();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_priority();
        step(0, 8'h00, 0, 0, 0, 8'h00);
        step(0, 8'h00, 0, 0, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/carry_chain_accum.md
# carry_chain_accum

Registered N-bit add/subtract accumulator for the genesis3 simulation library, built around the per-bit `adder_carry` primitive. It sits directly upstream of the flop cells: each bit's carry cell computes `p`/`g` and `sumout`, and the block captures the result into the accumulator register every enabled cycle. It provides a two-stage pipelined model with a sticky overflow flag. Mapped arithmetic and counter logic is checked against it in simulation.

## Interface
- `WIDTH`, 8: accumulator and operand width, ≥2.
- `INIT_VALUE`, `{WIDTH{1'b0}}`: value of `Q` after reset and after `CLR`.
- `C` input, 1 bit: clock, rising edge.
- `R` input, 1 bit: reset. Asynchronous, active-high.
- `E` input, 1 bit: operand valid/enable; accepts `D` and `SUB` this cycle.
- `D` input, `WIDTH` bits: operand.
- `SUB` input, 1 bit: 0 = `Q + D`, 1 = `Q - D`; sampled with `E`.
- `CLR` input, 1 bit: synchronous clear of `Q`, `OV` and the pipeline.
- `LD` input, 1 bit: synchronous load of `L` into `Q`.
- `L` input, `WIDTH` bits: load value.
- `Q` output, `WIDTH` bits: accumulator.
- `QV` output, 1 bit: one-cycle pulse, `Q` updated by an accumulate.
- `CO` output, 1 bit: carry out of the last accumulate; for subtract, 1 = no borrow.
- `OV` output, 1 bit: sticky two's-complement overflow.

## Operation
- Stage 1, operand register:
  - On `E`, capture `d1 <= SUB ? ~D : D`, `c1 <= SUB` and `v1 <= 1`.
  - Otherwise `v1 <= 0`; `d1` and `c1` hold.
- Stage 2, carry chain:
  - Per bit i: `p[i] = Q[i] ^ d1[i]`, `g[i] = Q[i] & d1[i]`.
  - Chain `cin[0] = c1`, `cin[i+1] = cout[i]` via `adder_carry`.
  - `sum = {sumout}`.
  - When `v1`: `Q <= sum`, `CO <= cout[WIDTH-1]`, `QV <= 1`.
  - `OV <= OV | (cin[WIDTH-1] ^ cout[WIDTH-1])`.
- Priority, highest first: `R` > `CLR` > `LD` > accumulate.
  - `CLR`: `Q <= INIT_VALUE`; `CO`, `OV`, `QV` and `v1` go to 0; a concurrent `E` operand is dropped.
  - `LD`: `Q <= L` and `QV <= 0`. The in-flight `v1` operand is discarded. `CO` and `OV` hold. A concurrent `E` is still captured into stage 1.
- Arithmetic is modulo 2^`WIDTH`; wrap-around is never blocked.
- `OV` stays set until `CLR` or `R`.
- Back-to-back `E` every cycle is supported at full rate, with no stalls. Feedback is through `Q` only.

## Timing
- Reset values, held while `R=1`:
  - `Q = INIT_VALUE`.
  - `QV`, `CO`, `OV` = 0.
  - Stage-1 registers = 0.
- Latency:
  - `E` sampled at edge n.
  - `Q`, `CO` and `OV` update at edge n+1.
  - `QV` is high for the cycle following edge n+1.
- `LD` and `CLR` take effect at the same edge they are sampled (latency 1).
- Simultaneous events:
  - `LD` at edge n+1 over a pending `v1` overwrites the result: `Q = L`, no `QV`.
  - `E` with `LD` at edge n: the operand is applied to the loaded `L` at n+1.
- `R` asserted mid-operation clears everything immediately. Release is synchronous to the next rising `C`, and no pending operand survives.
- All flops are rising-edge `C`. No combinational path from inputs to outputs.

## Structure
- Shared package `genesis3_pkg`:
  - Operation encoding constants `OP_ADD=1'b0`, `OP_SUB=1'b1`.
  - An overflow-detect helper function.
- One natural sub-module, `carry_chain`: a `WIDTH`-bit ripple of `adder_carry` instances, generating `sum`, `cout[WIDTH-1]` and `cin[WIDTH-1]`. It is reusable by future counter models.
- The top level holds the stage-1 register, the `Q` register, and the `QV`/`CO`/`OV` logic.

## Test plan
- Reset and init:
  - With `INIT_VALUE=8'h05`, assert `R` mid-stream with `E=1` → `Q=8'h05`, `QV=CO=OV=0` immediately.
  - After release, the first `E` with `D=1` → `Q=8'h06` two edges later.
- Add wrap:
  - `LD` `L=8'hFE`, then `E` `D=8'h03` `SUB=0` → `Q=8'h01`, `CO=1`, `OV=0`, one `QV` pulse.
- Signed overflow sticky:
  - `LD` `8'h7F`, `E` `D=8'h01` → `Q=8'h80`, `OV=1`.
  - Then `E` `D=8'h01` → `Q=8'h81`, `OV` remains 1 until `CLR`.
- Subtract and borrow:
  - `LD` `8'h02`, `E` `SUB=1` `D=8'h03` → `Q=8'hFF`, `CO=0`.
  - Then `SUB=1` `D=8'h01` → `Q=8'hFE`, `CO=1`.
- Back-to-back:
  - `E=1` for 4 cycles with `D=1,2,3,4` from `Q=0` → `Q=1,3,6,10` on consecutive edges; `QV` high 4 consecutive cycles.
- Priority collisions:
  - `CLR` with `E` and `LD` → `Q=INIT_VALUE`, `QV=0` next cycle.
  - `LD` `L=8'h10` while `v1` is pending → `Q=8'h10`, no `QV`.
